// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial data-memory controller.
// State encodings, bus widths and the lane-to-byte-offset mapping live here.
package mem_ctrl_pkg;

  localparam int unsigned RAM_BUS_W  = 32;
  localparam int unsigned BYTE_BUS_W = 8;
  localparam int unsigned NUM_LANES  = RAM_BUS_W / BYTE_BUS_W;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  // Lane 3 carries data[31:24] and sits at the lowest byte address.
  localparam logic [1:0] LANE3_OFFSET = 2'd0;
  localparam logic [1:0] LANE2_OFFSET = 2'd1;
  localparam logic [1:0] LANE1_OFFSET = 2'd2;
  localparam logic [1:0] LANE0_OFFSET = 2'd3;

  function automatic logic [1:0] lane_offset(input logic [1:0] lane);
    logic [1:0] off;
    case (lane)
      2'd3:    off = LANE3_OFFSET;
      2'd2:    off = LANE2_OFFSET;
      2'd1:    off = LANE1_OFFSET;
      default: off = LANE0_OFFSET;
    endcase
    return off;
  endfunction

  function automatic logic [NUM_LANES-1:0] lanes_below(input logic [1:0] lane);
    return (NUM_LANES'(1) << lane) - NUM_LANES'(1);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// MEM-stage request/response and 8-bit RAM port bundle for mem_ctrl.
// slave is the controller's view, master is the pipeline/RAM side.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 32
);
  logic                  mem_ce_i;
  logic                  mem_we_i;
  logic [RAM_BUS_W-1:0]  mem_addr_i;
  logic [NUM_LANES-1:0]  mem_sel_i;
  logic [RAM_BUS_W-1:0]  mem_data_i;
  logic [RAM_BUS_W-1:0]  mem_data_o;
  logic                  stallreq_o;
  logic [RAM_ADDR_W-1:0] ram_addr_o;
  logic                  ram_wr_o;
  logic [BYTE_BUS_W-1:0] ram_dout_o;
  logic [BYTE_BUS_W-1:0] ram_din_i;

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_din_i,
    output mem_data_o, stallreq_o, ram_addr_o, ram_wr_o, ram_dout_o
  );

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_din_i,
    input  mem_data_o, stallreq_o, ram_addr_o, ram_wr_o, ram_dout_o
  );
endinterface

// File: rtl/mem_ctrl_lane_pick.sv
// Priority pick of the highest selected lane at or below a lane pointer.
// Purely combinational; shareable with an instruction-fetch controller.
module mem_ctrl_lane_pick
  import mem_ctrl_pkg::*;
(
  input  logic [NUM_LANES-1:0] sel,
  input  logic [1:0]           ptr,
  output logic                 hit,
  output logic [1:0]           lane
);

  always_comb begin
    hit  = 1'b0;
    lane = 2'd0;
    // Ascending scan: the last match wins, giving the highest eligible lane.
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if ((i <= 32'(ptr)) && sel[i]) begin
        hit  = 1'b1;
        lane = i[1:0];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Data-memory controller: turns a 32-bit lane-selected MEM request into byte-serial
// RAM transfers and stalls the pipeline until done. Optional: MEMCTRL_PERF_CNT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 32,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_ctrl_if.slave   bus
`ifdef MEMCTRL_PERF_CNT_EN
  ,
  output logic [31:0] perf_access_o,
  output logic [31:0] perf_stall_o
`endif
);

  mc_state_e             state_q, state_d;
  logic                  we_q;
  logic [29:0]           addr_q;
  logic [NUM_LANES-1:0]  sel_q;
  logic [RAM_BUS_W-1:0]  wdata_q;
  logic [RAM_BUS_W-1:0]  rdata_q, rdata_d;
  logic [1:0]            ptr_q, ptr_d;
  logic                  pend_q, pend_d;
  logic [1:0]            pend_lane_q, pend_lane_d;
  logic                  issued_q, issued_d;

  logic                  latch;
  logic                  issue;
  logic                  stall;
  logic                  hit;
  logic [1:0]            lane;
  logic                  more;

  mem_ctrl_lane_pick u_lane_pick (
    .sel  (sel_q),
    .ptr  (ptr_q),
    .hit  (hit),
    .lane (lane)
  );

  assign more = |(sel_q & lanes_below(lane));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pend_d      = 1'b0;
    pend_lane_d = pend_lane_q;
    issued_d    = issued_q;
    latch       = 1'b0;
    issue       = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        stall = bus.mem_ce_i;
        if (bus.mem_ce_i) begin
          latch    = 1'b1;
          ptr_d    = 2'd3;
          issued_d = 1'b0;
          state_d  = (bus.mem_sel_i == '0) ? MC_DONE : MC_BUSY;
        end
      end
      MC_BUSY: begin
        stall = 1'b1;
        if (issued_q) begin
          // Loads only: the last lane's byte is captured this cycle.
          state_d = MC_DONE;
        end else if (hit) begin
          issue = 1'b1;
          ptr_d = lane - 2'd1;
          if (we_q) begin
            if (!more) state_d = MC_DONE;
          end else begin
            pend_d      = 1'b1;
            pend_lane_d = lane;
            issued_d    = !more;
          end
        end else begin
          state_d = MC_DONE;
        end
      end
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (latch) begin
      rdata_d = '0;
    end else if (pend_q) begin
      rdata_d[{pend_lane_q, 3'b000} +: BYTE_BUS_W] = bus.ram_din_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MC_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ptr_q       <= 2'd3;
      pend_q      <= 1'b0;
      pend_lane_q <= 2'd0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
      issued_q    <= issued_d;
      if (latch) begin
        we_q    <= bus.mem_we_i;
        addr_q  <= bus.mem_addr_i[31:2];
        sel_q   <= bus.mem_sel_i;
        wdata_q <= bus.mem_data_i;
      end
    end
  end

  // RAM strobes derive from the state register so reset removes them at once.
  assign bus.ram_wr_o   = issue & we_q;
  assign bus.ram_addr_o = issue ? RAM_ADDR_W'({addr_q, lane_offset(lane)}) : '0;
  assign bus.ram_dout_o = (issue & we_q) ? wdata_q[{lane, 3'b000} +: BYTE_BUS_W] : '0;
  assign bus.mem_data_o = rdata_q;
  assign bus.stallreq_o = stall;

`ifdef MEMCTRL_PERF_CNT_EN
  logic [31:0] perf_access_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_access_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (latch) perf_access_q <= perf_access_q + 32'd1;
      if (stall) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_access_o = perf_access_q;
  assign perf_stall_o  = perf_stall_q;
`endif

  // Word-aligned addressing drops addr[1:0]; RD_LAT is fixed at 1 in this revision.
  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr_i[1:0], RD_LAT[0]};

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Data-memory controller directly downstream of the MEM stage.
- Takes the MEM stage's 32-bit lane-selected request (ce/we/addr/sel/data) and turns it into byte-serial transfers on an 8-bit RAM port.
- Returns the assembled read word to the MEM stage.
- Holds the pipeline via a stall request until the access completes.

Parameters:
- RAM_ADDR_W, 32, width of the byte address driven to RAM.
- RD_LAT, 1, RAM read latency in cycles (fixed 1 in this revision; other values are illegal).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- mem_ce_i  in  1  request valid, from MEM stage
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  byte address; bits [1:0] ignored for lane decode
- mem_sel_i  in  4  lane enables; sel[3] is offset 0 (data[31:24]), sel[0] is offset 3 (data[7:0])
- mem_data_i  in  32  store data, lane-aligned
- mem_data_o  out  32  load data, lane-aligned; unselected lanes read 0
- stallreq_o  out  1  pipeline hold request
- ram_addr_o  out  RAM_ADDR_W  byte address to RAM
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte, valid RD_LAT cycles after its address

Behaviour:
- Reset (rst=0, async): state IDLE; ram_wr_o=0; ram_addr_o=0; ram_dout_o=0; mem_data_o=0; internal lane pointer and pending-capture flag cleared.
- Reset mid-transfer aborts immediately. No further RAM strobes are issued. Partial stores are not rolled back.
- States:
  - IDLE: no transfer in progress.
  - BUSY: issuing byte transfers.
  - DONE: one cycle; result is presented and the pipeline advances.
- IDLE:
  - If mem_ce_i=1, latch we/addr[31:2]/sel/data, clear mem_data_o, then go to BUSY.
  - If sel=0000, go to DONE instead; no bus activity.
  - stallreq_o = mem_ce_i (combinational).
- BUSY:
  - Each cycle, issue the next selected lane in order sel[3]→sel[0].
  - ram_addr_o = {addr[31:2], offset}, where offset = 0..3 for lanes 3..0.
  - Unselected lanes are skipped with no idle cycle.
  - Store: ram_wr_o=1 and ram_dout_o = that lane's byte, for one cycle per lane.
  - Load: ram_wr_o=0. ram_din_i is captured into the matching mem_data_o lane on the following cycle.
  - Go to DONE when the last lane has issued (store), or when its data has been captured (load).
  - stallreq_o=1.
- DONE: stallreq_o=0; mem_data_o holds the final word; ram_wr_o=0. Next state is always IDLE. The held request is therefore not re-served.
- Latency for N selected lanes, measured as stall cycles from the request:
  - Store: N+1.
  - Load: N+2.
  - sel=0000: 1.
- mem_data_o keeps its value through IDLE until the next request is latched.
- Input changes while in BUSY/DONE are ignored; the latched copy is used.
- Non-contiguous sel patterns (e.g. 1010) are legal and served lane by lane.

Optional Feature:
- Macro: MEMCTRL_PERF_CNT_EN.
- Defined:
  - Adds output perf_access_o[31:0], incremented on every IDLE→BUSY or IDLE→DONE transition.
  - Adds output perf_stall_o[31:0], incremented every cycle stallreq_o=1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file gets:
  - State encodings MC_IDLE/MC_BUSY/MC_DONE (2 bits).
  - RamBus/ByteBus widths.
  - Lane-to-offset mapping constants.
- No sub-module required.
- mem_ctrl_lane_pick (priority pick of the next selected lane at or below the pointer) is a natural small combinational sub-module if reused by an instruction-fetch controller.

Test Plan:
- SW, addr=0x100, sel=1111, data=0xDEADBEEF → ram writes DE@0x100, AD@0x101, BE@0x102, EF@0x103 on consecutive cycles; stallreq_o high 5 cycles total, low on DONE.
- LW, addr=0x200, RAM holds 11,22,33,44 at 0x200..0x203 → mem_data_o=0x11223344 in DONE; 6 stall cycles.
- LB-style sel=0010, addr=0x302, RAM[0x302]=0x9A → single read at 0x302; mem_data_o=0x00009A00; 3 stall cycles.
- SH sel=0011, addr=0x402, data=0x0000CAFE → writes CA@0x402, FE@0x403 only; no strobe to 0x400/0x401.
- Back-to-back requests:
  - Setup: LW then SB; ce held through DONE.
  - Required: exactly one LW sequence, then IDLE, then SB starts the following cycle.
  - Required: no duplicate access.
- Reset pulse (rst=0) during the second byte of a SW → ram_wr_o drops asynchronously; state IDLE; stallreq_o=mem_ce_i after release. With MEMCTRL_PERF_CNT_EN, counters read 0.
